// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Exports the FSM state enum and the default operand width.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_e;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin.
// Ports: a, b, bin (in) ; d (difference), bout (borrow-out).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when a==b and a borrow comes in.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with A, B, Bin;
//        out_valid/out_ready with Diff, Bout; busy high while shifting.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_e       r_state;
    sub_state_e       w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_diff_nx;

    full_subtractor u_fs (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // New difference bit enters at the MSB so the LSB lands at bit 0.
    assign w_diff_nx = {w_d, r_diff_sh[WIDTH-1:1]};

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == SHIFT);
    assign out_valid = (r_state == DONE);
    assign Diff      = r_diff;
    assign Bout      = r_bout;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_br      <= 1'b0;
            r_cnt     <= '0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh <= A;
                        r_b_sh <= B;
                        r_br   <= Bin;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_br      <= w_bout;
                    r_diff_sh <= w_diff_nx;
                    // Hold the counter on the last bit so it never wraps.
                    if (r_cnt == LAST) begin
                        r_diff <= w_diff_nx;
                        r_bout <= w_bout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
